// File: rtl/rf_pkg.sv
// Shared constants and types for the scoreboarded register file.
package rf_pkg;

    localparam int unsigned RF_XLEN  = 32;
    localparam int unsigned RF_NREGS = 32;
    localparam int unsigned RF_NREAD = 2;
    localparam int unsigned RF_AW    = $clog2(RF_NREGS);

    typedef logic [RF_AW-1:0] rf_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits tracking pending writebacks.
// Priority per register: flush > issue > writeback.
module rf_scoreboard #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_v,
    input  logic [AW-1:0]    iss_a,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             flush,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (iss_v && iss_a == AW'(r) && r != 0) begin
                // A younger producer outranks the writeback of the older one.
                busy_d[r] = 1'b1;
            end else if (we && wa == AW'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass and a busy scoreboard
// so the hazard unit can stall on pending operands.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = RF_XLEN,
    parameter int unsigned NREGS = RF_NREGS,
    parameter int unsigned NREAD = RF_NREAD,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  iss_v,
    input  logic [AW-1:0]         iss_a,
    input  logic                  flush
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [NREGS-1:0] busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && wa != '0) begin
            mem_q[wa] <= wd;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk   (clk),
        .rst_n (rst_n),
        .iss_v (iss_v),
        .iss_a (iss_a),
        .we    (we),
        .wa    (wa),
        .flush (flush),
        .busy  (busy)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [AW-1:0] rai;
        logic          hit;

        assign rai = ra[i*AW +: AW];
        assign hit = we && (wa == rai);

        // Outputs are forced low during reset so the bypass cannot leak wd.
        assign rd[i*XLEN +: XLEN] = (!rst_n || rai == '0) ? '0 :
                                    hit                   ? wd : mem_q[rai];
        assign rbusy[i] = rst_n && busy[rai] && !hit;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Table-driven bench for regfile_sb with an expectation queue and
// hand-written reset sequences.
module tb_regfile_sb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NREAD = 2;
    localparam int unsigned AW    = 5;
    localparam int          NV    = 20;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  we;
    logic [AW-1:0]         wa;
    logic [XLEN-1:0]       wd;
    logic [NREAD*AW-1:0]   ra;
    logic [NREAD*XLEN-1:0] rd;
    logic [NREAD-1:0]      rbusy;
    logic                  iss_v;
    logic [AW-1:0]         iss_a;
    logic                  flush;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_sb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ra    (ra),
        .rd    (rd),
        .rbusy (rbusy),
        .iss_v (iss_v),
        .iss_a (iss_a),
        .flush (flush)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        iss_v;
        logic [4:0]  iss_a;
        logic        flush;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_b;
    } vec_t;

    typedef struct {
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  b;
    } exp_t;

    vec_t vecs [NV];
    exp_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we    = 1'b0;
        wa    = '0;
        wd    = '0;
        iss_v = 1'b0;
        iss_a = '0;
        flush = 1'b0;
    endtask

    initial begin
        exp_t e;

        // we wa wd ra0 ra1 iss_v iss_a flush | rd0 rd1 {b1,b0}
        vecs[0]  = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0,
                     32'h0, 32'h0, 2'b00};
        vecs[1]  = '{1'b1, 5'd3, 32'h1234_5678, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0,
                     32'h0, 32'h0, 2'b00};
        vecs[2]  = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0,
                     32'h1234_5678, 32'h1234_5678, 2'b00};
        vecs[3]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                     32'h0, 32'h0, 2'b00};
        vecs[4]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0,
                     32'h0, 32'h1234_5678, 2'b00};
        vecs[5]  = '{1'b1, 5'd7, 32'hA5A5_0001, 5'd8, 5'd7, 1'b0, 5'd0, 1'b0,
                     32'h0, 32'hA5A5_0001, 2'b00};
        vecs[6]  = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd8, 1'b0, 5'd0, 1'b0,
                     32'hA5A5_0001, 32'h0, 2'b00};
        vecs[7]  = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0,
                     32'h0, 32'h0, 2'b00};
        vecs[8]  = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd3, 1'b0, 5'd0, 1'b0,
                     32'h0, 32'h1234_5678, 2'b01};
        vecs[9]  = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd7, 1'b0, 5'd0, 1'b0,
                     32'h0, 32'hA5A5_0001, 2'b01};
        vecs[10] = '{1'b1, 5'd9, 32'h0000_0055, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0,
                     32'h55, 32'h55, 2'b00};
        vecs[11] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd3, 1'b0, 5'd0, 1'b0,
                     32'h55, 32'h1234_5678, 2'b00};
        vecs[12] = '{1'b1, 5'd4, 32'h0000_0044, 5'd4, 5'd4, 1'b1, 5'd4, 1'b0,
                     32'h44, 32'h44, 2'b00};
        vecs[13] = '{1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0,
                     32'h44, 32'h0, 2'b01};
        vecs[14] = '{1'b0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b1, 5'd6, 1'b1,
                     32'h44, 32'h0, 2'b01};
        vecs[15] = '{1'b0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b0, 5'd0, 1'b0,
                     32'h44, 32'h0, 2'b00};
        vecs[16] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0,
                     32'h0, 32'h0, 2'b00};
        vecs[17] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                     32'h0, 32'h0, 2'b00};
        vecs[18] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd4, 1'b1, 5'd9, 1'b0,
                     32'h55, 32'h44, 2'b00};
        vecs[19] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0,
                     32'h55, 32'h55, 2'b11};

        // Reset held with a write, issue and bypass-eligible read all active.
        idle_inputs();
        rst_n = 1'b0;
        we    = 1'b1;
        wa    = 5'd5;
        wd    = 32'hDEAD_BEEF;
        iss_v = 1'b1;
        iss_a = 5'd5;
        ra    = {5'd5, 5'd5};
        repeat (2) @(posedge clk);
        #1;
        check("in_reset rd0", rd[31:0], 32'h0);
        check("in_reset rd1", rd[63:32], 32'h0);
        check("in_reset rbusy", 32'(rbusy), 32'h0);
        rst_n = 1'b1;
        idle_inputs();

        for (int i = 0; i < NV; i++) begin
            we    = vecs[i].we;
            wa    = vecs[i].wa;
            wd    = vecs[i].wd;
            ra    = {vecs[i].ra1, vecs[i].ra0};
            iss_v = vecs[i].iss_v;
            iss_a = vecs[i].iss_a;
            flush = vecs[i].flush;
            exp_q.push_back('{vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_b});
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("v%0d rd0", i), rd[31:0], e.rd0);
            check($sformatf("v%0d rd1", i), rd[63:32], e.rd1);
            check($sformatf("v%0d rbusy", i), 32'(rbusy), 32'(e.b));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset pulse between edges with reg9 busy and holding 0x55.
        idle_inputs();
        ra = {5'd9, 5'd9};
        #1;
        check("pre_rst rd0", rd[31:0], 32'h55);
        check("pre_rst rbusy", 32'(rbusy), 32'h3);
        rst_n = 1'b0;
        we    = 1'b1;
        wa    = 5'd9;
        wd    = 32'h77;
        #1;
        check("mid_rst rd0", rd[31:0], 32'h0);
        check("mid_rst rd1", rd[63:32], 32'h0);
        check("mid_rst rbusy", 32'(rbusy), 32'h0);
        #1;
        rst_n = 1'b1;
        idle_inputs();
        #1;
        check("post_rst rd0", rd[31:0], 32'h0);
        check("post_rst rbusy", 32'(rbusy), 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_edge rd1", rd[63:32], 32'h0);
        check("post_rst_edge rbusy", 32'(rbusy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
